// File: rtl/alu_rr_sequencer.sv
// Fetch/execute control-step sequencer for register-register ALU instructions.
// Optional HI/LO write-back for multiply/divide is enabled by defining SEQ_HILO_EN.
module alu_rr_sequencer #(
    parameter int                  IR_W        = 32,
    parameter int                  OPCODE_W    = 5,
    parameter int                  REG_FIELD_W = 4,
    parameter int                  NUM_REGS    = 16,
    parameter logic [OPCODE_W-1:0] OP_MIN      = 5'd3,
    parameter logic [OPCODE_W-1:0] OP_MAX      = 5'd12,
    parameter logic [OPCODE_W-1:0] OP_MUL      = 5'd15,
    parameter logic [OPCODE_W-1:0] OP_DIV      = 5'd16,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                Start,
    input  logic                MemReady,
    input  logic [IR_W-1:0]     IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                ZHighout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPCODE_W-1:0] AluOp,
    output logic                HIin,
    output logic                LOin,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic [3:0]          Step
);

    localparam int CNT_W   = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam int RA_MSB  = IR_W - OPCODE_W - 1;
    localparam int RB_MSB  = RA_MSB - REG_FIELD_W;
    localparam int RC_MSB  = RB_MSB - REG_FIELD_W;
    localparam int LOW_W   = RC_MSB + 1 - REG_FIELD_W;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               set_err, clr_err, cnt_clr, cnt_inc;

    logic [OPCODE_W-1:0]    opcode;
    logic [REG_FIELD_W-1:0] ra, rb, rc;
    logic                   op_legal, reg_bad, legal, is_hilo, timeout_hit;
    logic                   unused_ir;

    assign opcode    = IR[IR_W-1 -: OPCODE_W];
    assign ra        = IR[RA_MSB -: REG_FIELD_W];
    assign rb        = IR[RB_MSB -: REG_FIELD_W];
    assign rc        = IR[RC_MSB -: REG_FIELD_W];
    assign unused_ir = ^IR[LOW_W-1:0];

`ifdef SEQ_HILO_EN
    assign is_hilo  = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
    assign is_hilo  = 1'b0;
`endif
    assign op_legal = ((opcode >= OP_MIN) && (opcode <= OP_MAX)) || is_hilo;

    // Range check only exists when the field can address unimplemented registers.
    if (NUM_REGS < (2 ** REG_FIELD_W)) begin : g_reg_range
        localparam logic [REG_FIELD_W-1:0] LIMIT = REG_FIELD_W'(NUM_REGS);
        assign reg_bad = (ra >= LIMIT) || (rb >= LIMIT) || (rc >= LIMIT);
    end else begin : g_reg_full
        assign reg_bad = 1'b0;
    end

    assign legal       = op_legal && !reg_bad;
    assign timeout_hit = (CNT_W'(cnt_q + 1'b1) == CNT_W'(MEM_TIMEOUT));

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_FIELD_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == REG_FIELD_W'(i));
        return v;
    endfunction

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (clr_err)      err_q <= 1'b0;
            else if (set_err) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        clr_err = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: if (Start) begin
                state_d = S_T0;
                clr_err = 1'b1;
                cnt_clr = 1'b1;
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (MemReady) begin
                    state_d = S_T2;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (legal) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = is_hilo ? S_T6 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode; T3 strobes additionally gated by the decode result.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Rout     = '0;
        Rin      = '0;
        AluOp    = '0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Done     = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: if (legal) begin
                Rout = onehot(rb);
                Yin  = 1'b1;
            end
            S_T4: begin
                Rout  = onehot(rc);
                Zin   = 1'b1;
                AluOp = opcode;
            end
            S_T5: begin
                Zlowout = 1'b1;
`ifdef SEQ_HILO_EN
                LOin    = is_hilo;
`endif
                if (!is_hilo) begin
                    Rin  = onehot(ra);
                    Done = 1'b1;
                end
            end
`ifdef SEQ_HILO_EN
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign Err  = err_q;
    assign Step = state_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer; a second instance with NUM_REGS=8 exercises register range errors.
module tb_alu_rr_sequencer;

    logic        Clock, Clear, Start, MemReady;
    logic [31:0] IR;

    logic        PCout, MARin, IncPC, Zin, Zlowout, ZHighout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rout, Rin;
    logic [4:0]  AluOp;
    logic        HIin, LOin, Busy, Done, Err;
    logic [3:0]  Step;

    logic        PCout_8, MARin_8, IncPC_8, Zin_8, Zlowout_8, ZHighout_8, PCin_8, Read_8, MDRin_8, MDRout_8, IRin_8, Yin_8;
    logic [7:0]  Rout_8, Rin_8;
    logic [4:0]  AluOp_8;
    logic        HIin_8, LOin_8, Busy_8, Done_8, Err_8;
    logic [3:0]  Step_8;

    logic [15:0] strobes, strobes8;
    int checks = 0;
    int errors = 0;

    assign strobes  = {PCout, MARin, IncPC, Zin, Zlowout, ZHighout, PCin, Read, MDRin, MDRout, IRin, Yin,
                       HIin, LOin, Busy, Done};
    assign strobes8 = {PCout_8, MARin_8, IncPC_8, Zin_8, Zlowout_8, ZHighout_8, PCin_8, Read_8, MDRin_8,
                       MDRout_8, IRin_8, Yin_8, HIin_8, LOin_8, Busy_8, Done_8};

    alu_rr_sequencer u_dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Rout(Rout), .Rin(Rin), .AluOp(AluOp), .HIin(HIin), .LOin(LOin),
        .Busy(Busy), .Done(Done), .Err(Err), .Step(Step)
    );

    alu_rr_sequencer #(.NUM_REGS(8)) u_dut8 (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
        .PCout(PCout_8), .MARin(MARin_8), .IncPC(IncPC_8), .Zin(Zin_8), .Zlowout(Zlowout_8),
        .ZHighout(ZHighout_8), .PCin(PCin_8), .Read(Read_8), .MDRin(MDRin_8), .MDRout(MDRout_8),
        .IRin(IRin_8), .Yin(Yin_8), .Rout(Rout_8), .Rin(Rin_8), .AluOp(AluOp_8), .HIin(HIin_8),
        .LOin(LOin_8), .Busy(Busy_8), .Done(Done_8), .Err(Err_8), .Step(Step_8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Clear = 1'b1; Start = 1'b0; MemReady = 1'b0; IR = '0;
        tick; tick;
        checks++; if (strobes !== 16'h0000) begin errors++; $display("FAIL reset_strobes got %h exp 0000", strobes); end
        checks++; if (Step !== 4'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", Step); end
        checks++; if (Err !== 1'b0 || Rout !== 16'h0 || Rin !== 16'h0 || AluOp !== 5'd0) begin
            errors++; $display("FAIL reset_misc got err=%b rout=%h rin=%h aluop=%h exp 0", Err, Rout, Rin, AluOp);
        end
        Clear = 1'b0;
        tick;
    endtask

    task automatic test_and;
        logic [15:0] e_str  [6] = '{16'hF002, 16'h0B82, 16'h0062, 16'h0012, 16'h1002, 16'h0803};
        logic [15:0] e_rout [6] = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0010, 16'h0};
        logic [15:0] e_rin  [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0020};
        logic [4:0]  e_op   [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01001, 5'd0};
        IR = 32'h4A920000; MemReady = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (Step !== 4'(i + 1) || strobes !== e_str[i]) begin
                errors++; $display("FAIL and_t%0d_ctrl got step=%0d str=%h exp step=%0d str=%h", i, Step, strobes, i + 1, e_str[i]);
            end
            checks++; if (Rout !== e_rout[i] || Rin !== e_rin[i] || AluOp !== e_op[i]) begin
                errors++; $display("FAIL and_t%0d_sel got rout=%h rin=%h op=%h exp rout=%h rin=%h op=%h",
                                   i, Rout, Rin, AluOp, e_rout[i], e_rin[i], e_op[i]);
            end
            tick;
        end
        checks++; if (Step !== 4'd0 || strobes !== 16'h0 || Err !== 1'b0) begin
            errors++; $display("FAIL and_idle got step=%0d str=%h err=%b exp 0/0000/0", Step, strobes, Err);
        end
    endtask

    task automatic test_mem_wait;
        IR = 32'h4A920000; MemReady = 1'b0; Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++; if (Step !== 4'd2 || strobes !== 16'h0B82) begin
                errors++; $display("FAIL memwait_t1_%0d got step=%0d str=%h exp 2/0b82", i, Step, strobes);
            end
            if (i == 3) MemReady = 1'b1;
            tick;
        end
        checks++; if (Step !== 4'd3 || Err !== 1'b0) begin
            errors++; $display("FAIL memwait_t2 got step=%0d err=%b exp 3/0", Step, Err);
        end
        tick; tick; tick;
        checks++; if (Step !== 4'd6 || strobes !== 16'h0803 || Rin !== 16'h0020) begin
            errors++; $display("FAIL memwait_t5 got step=%0d str=%h rin=%h exp 6/0803/0020", Step, strobes, Rin);
        end
        tick;
        checks++; if (Step !== 4'd0 || Err !== 1'b0) begin
            errors++; $display("FAIL memwait_idle got step=%0d err=%b exp 0/0", Step, Err);
        end
    endtask

    task automatic test_timeout;
        IR = 32'h4A920000; MemReady = 1'b0; Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        for (int i = 0; i < 15; i++) begin
            checks++; if (Step !== 4'd2 || Err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait_%0d got step=%0d err=%b exp 2/0", i, Step, Err);
            end
            tick;
        end
        checks++; if (Step !== 4'd0 || Err !== 1'b1 || Busy !== 1'b0) begin
            errors++; $display("FAIL timeout_abort got step=%0d err=%b busy=%b exp 0/1/0", Step, Err, Busy);
        end
        MemReady = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        checks++; if (Step !== 4'd1 || Err !== 1'b0) begin
            errors++; $display("FAIL timeout_restart got step=%0d err=%b exp 1/0", Step, Err);
        end
        for (int i = 0; i < 6; i++) tick;
        checks++; if (Step !== 4'd0 || Err !== 1'b0) begin
            errors++; $display("FAIL timeout_rerun got step=%0d err=%b exp 0/0", Step, Err);
        end
    endtask

    task automatic test_illegal;
        IR = 32'hF8000000; MemReady = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (Rin !== 16'h0) begin errors++; $display("FAIL illop_rin_%0d got %h exp 0000", i, Rin); end
            if (i == 3) begin
                checks++; if (Step !== 4'd4 || strobes !== 16'h0002 || Rout !== 16'h0) begin
                    errors++; $display("FAIL illop_t3 got step=%0d str=%h rout=%h exp 4/0002/0000", Step, strobes, Rout);
                end
            end
            if (i == 4) begin
                checks++; if (Step !== 4'd0 || Err !== 1'b1) begin
                    errors++; $display("FAIL illop_err got step=%0d err=%b exp 0/1", Step, Err);
                end
            end
            if (i < 4) tick;
        end
        IR = 32'h4C800000; Start = 1'b1;
        tick;
        Start = 1'b0;
        tick; tick; tick;
        checks++; if (strobes8 !== 16'h0002 || Rout_8 !== 8'h0 || strobes !== 16'h0012) begin
            errors++; $display("FAIL illreg_t3 got str8=%h rout8=%h str=%h exp 0002/00/0012", strobes8, Rout_8, strobes);
        end
        tick;
        checks++; if (Err_8 !== 1'b1 || Step_8 !== 4'd0 || Step !== 4'd5 || Err !== 1'b0) begin
            errors++; $display("FAIL illreg_err got err8=%b step8=%0d step=%0d err=%b exp 1/0/5/0", Err_8, Step_8, Step, Err);
        end
        tick;
        checks++; if (Rin !== 16'h0200 || Rin_8 !== 8'h00) begin
            errors++; $display("FAIL illreg_rin got rin=%h rin8=%h exp 0200/00", Rin, Rin_8);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        IR = 32'h4A920000; MemReady = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        tick; tick; tick; tick;
        checks++; if (Step !== 4'd5) begin errors++; $display("FAIL midrst_pre got step=%0d exp 5", Step); end
        Clear = 1'b1;
        #1;
        checks++; if (strobes !== 16'h0 || Rout !== 16'h0 || AluOp !== 5'd0 || Step !== 4'd0) begin
            errors++; $display("FAIL midrst_async got str=%h rout=%h op=%h step=%0d exp all 0", strobes, Rout, AluOp, Step);
        end
        tick;
        Clear = 1'b0;
        tick;
        checks++; if (strobes !== 16'h0 || Rin !== 16'h0) begin
            errors++; $display("FAIL midrst_hold got str=%h rin=%h exp 0", strobes, Rin);
        end
        Start = 1'b1;
        tick;
        Start = 1'b0;
        checks++; if (Step !== 4'd1 || strobes !== 16'hF002) begin
            errors++; $display("FAIL midrst_restart got step=%0d str=%h exp 1/f002", Step, strobes);
        end
        for (int i = 0; i < 6; i++) tick;
        checks++; if (Step !== 4'd0) begin errors++; $display("FAIL midrst_done got step=%0d exp 0", Step); end
    endtask

    task automatic test_hilo;
        IR = 32'h78918000; MemReady = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        tick; tick; tick;
`ifdef SEQ_HILO_EN
        checks++; if (strobes !== 16'h0012 || Rout !== 16'h0004) begin
            errors++; $display("FAIL hilo_t3 got str=%h rout=%h exp 0012/0004", strobes, Rout);
        end
        tick;
        checks++; if (strobes !== 16'h1002 || Rout !== 16'h0008 || AluOp !== 5'd15) begin
            errors++; $display("FAIL hilo_t4 got str=%h rout=%h op=%h exp 1002/0008/0f", strobes, Rout, AluOp);
        end
        tick;
        checks++; if (Step !== 4'd6 || strobes !== 16'h0806 || Rin !== 16'h0) begin
            errors++; $display("FAIL hilo_t5 got step=%0d str=%h rin=%h exp 6/0806/0000", Step, strobes, Rin);
        end
        tick;
        checks++; if (Step !== 4'd7 || strobes !== 16'h040B) begin
            errors++; $display("FAIL hilo_t6 got step=%0d str=%h exp 7/040b", Step, strobes);
        end
        tick;
        checks++; if (Step !== 4'd0 || Err !== 1'b0) begin
            errors++; $display("FAIL hilo_idle got step=%0d err=%b exp 0/0", Step, Err);
        end
`else
        checks++; if (strobes !== 16'h0002 || Rout !== 16'h0) begin
            errors++; $display("FAIL mul_illegal_t3 got str=%h rout=%h exp 0002/0000", strobes, Rout);
        end
        tick;
        checks++; if (Step !== 4'd0 || Err !== 1'b1 || HIin !== 1'b0 || LOin !== 1'b0) begin
            errors++; $display("FAIL mul_illegal_err got step=%0d err=%b hi=%b lo=%b exp 0/1/0/0", Step, Err, HIin, LOin);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_and;
        test_mem_wait;
        test_timeout;
        test_illegal;
        test_reset_mid;
        test_hilo;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
